// File: rtl/reg_file_dump_pkg.sv
// Shared widths, state encodings and index helper for the register file dump reader.
package reg_file_dump_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned XLEN   = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [XLEN-1:0]   data_t;

    localparam logic [1:0] DUMP_IDLE = 2'd0;
    localparam logic [1:0] DUMP_READ = 2'd1;
    localparam logic [1:0] DUMP_SEND = 2'd2;
    localparam logic [1:0] DUMP_FIN  = 2'd3;

    // Index advance wraps naturally at 2^ADDR_W.
    function automatic addr_t next_idx(input addr_t i);
        return i + addr_t'(1);
    endfunction

endpackage

// File: rtl/reg_file_dump_if.sv
// Register file read port plus the valid/ready word stream of the dump reader.
interface reg_file_dump_if;
    import reg_file_dump_pkg::*;

    addr_t rf_addr;
    data_t rf_data;
    logic  out_valid;
    logic  out_ready;
    addr_t out_index;
    data_t out_data;

    modport master (
        output rf_addr,
        input  rf_data,
        output out_valid,
        input  out_ready,
        output out_index,
        output out_data
    );

    modport slave (
        input  rf_addr,
        output rf_data,
        input  out_valid,
        output out_ready,
        input  out_index,
        input  out_data
    );

endinterface

// File: rtl/reg_file_dump.sv
// Walks register indices first..last (with wrap) through a combinational rf read port
// and streams (index, value) pairs out over valid/ready.
module reg_file_dump
    import reg_file_dump_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  addr_t                  first_addr,
    input  addr_t                  last_addr,
    output logic                   busy,
    output logic                   done,
    reg_file_dump_if.master        bus
);

    logic [1:0] state_q, state_d;
    addr_t      idx_q, idx_d;
    addr_t      last_q, last_d;
    addr_t      oidx_q, oidx_d;
    data_t      odata_q, odata_d;
    logic       valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            oidx_q  <= '0;
            odata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            oidx_q  <= oidx_d;
            odata_q <= odata_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        oidx_d  = oidx_q;
        odata_d = odata_q;
        valid_d = valid_q;
        if (abort && state_q != DUMP_IDLE) begin
            // A word accepted this cycle is still delivered; only the stream stops.
            state_d = DUMP_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                DUMP_IDLE: begin
                    if (start && !abort) begin
                        idx_d   = first_addr;
                        last_d  = last_addr;
                        state_d = DUMP_READ;
                    end
                end
                DUMP_READ: begin
                    odata_d = bus.rf_data;
                    oidx_d  = idx_q;
                    valid_d = 1'b1;
                    state_d = DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (bus.out_ready) begin
                        valid_d = 1'b0;
                        if (idx_q == last_q) begin
                            state_d = DUMP_FIN;
                        end else begin
                            idx_d   = next_idx(idx_q);
                            state_d = DUMP_READ;
                        end
                    end
                end
                default: state_d = DUMP_IDLE;
            endcase
        end
    end

    // rf_addr follows the registered index in every state.
    assign bus.rf_addr   = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.out_index = oidx_q;
    assign bus.out_data  = odata_q;
    assign busy          = (state_q != DUMP_IDLE);
    assign done          = (state_q == DUMP_FIN) && !abort;

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: full dump, wrap, single word, backpressure, abort, reset.
module tb_reg_file_dump;
    import reg_file_dump_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  start;
    logic  abort;
    addr_t first_addr;
    addr_t last_addr;
    logic  busy;
    logic  done;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_dump_if bus ();

    reg_file_dump u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Register file model: r0 hardwired to zero, others preloaded to 0x1000_0000 + i.
    function automatic data_t rf_val(input addr_t i);
        if (i == '0) return '0;
        return 32'h1000_0000 + 32'(i);
    endfunction

    assign bus.rf_data = rf_val(bus.rf_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_dump(input addr_t f, input addr_t l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Consume words until done; exp_done_cyc != 0 also checks done timing and busy length.
    task automatic collect(input addr_t exp_first, input int count, input bit rand_ready,
                           input int exp_done_cyc);
        addr_t exp_idx = exp_first;
        int    cyc = 1;
        int    busy_n = 0;
        int    got = 0;
        bit    stall = 0;
        bit    done_seen = 0;
        addr_t held_idx = '0;
        data_t held_data = '0;
        while (!done_seen && cyc <= 400) begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy) busy_n++;
            if (stall) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_index", 32'(bus.out_index), 32'(held_idx));
                chk("stall_data", bus.out_data, held_data);
            end
            stall = 0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    chk("word_index", 32'(bus.out_index), 32'(exp_idx));
                    chk("word_data", bus.out_data, rf_val(exp_idx));
                    got++;
                    exp_idx = exp_idx + addr_t'(1);
                end else begin
                    stall     = 1;
                    held_idx  = bus.out_index;
                    held_data = bus.out_data;
                end
            end
            if (done) begin
                done_seen = 1;
                chk("word_count", 32'(got), 32'(count));
                if (exp_done_cyc != 0) begin
                    chk("done_cycle", 32'(cyc), 32'(exp_done_cyc));
                    chk("busy_cycles", 32'(busy_n), 32'(2 * count + 1));
                end
            end
            tick();
            cyc++;
        end
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        first_addr    = '0;
        last_addr     = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
        chk("rst_index", 32'(bus.out_index), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        rst = 1'b0;
        tick();

        // Full range dump, sink always ready.
        bus.out_ready = 1'b1;
        start_dump(5'd0, 5'd31);
        chk("read_busy", 32'(busy), 32'd1);
        chk("read_novalid", 32'(bus.out_valid), 32'd0);
        collect(5'd0, 32, 1'b0, 65);

        // Wrapping range 30..1 and a single-word range.
        start_dump(5'd30, 5'd1);
        collect(5'd30, 4, 1'b0, 9);
        start_dump(5'd5, 5'd5);
        collect(5'd5, 1, 1'b0, 3);

        // Random backpressure.
        start_dump(5'd3, 5'd20);
        collect(5'd3, 18, 1'b1, 0);

        // Abort during the third SEND; that word is accepted in the same cycle.
        bus.out_ready = 1'b1;
        start_dump(5'd0, 5'd31);
        for (int i = 0; i < 5; i++) tick();
        chk("abort_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("abort_pre_index", 32'(bus.out_index), 32'd2);
        abort = 1'b1;
        chk("abort_no_done", 32'(done), 32'd0);
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        chk("abort_done2", 32'(done), 32'd0);
        start_dump(5'd7, 5'd9);
        collect(5'd7, 3, 1'b0, 7);

        // start and abort together in IDLE: no dump begins.
        abort = 1'b1;
        start_dump(5'd4, 5'd6);
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);

        // Reset mid-dump.
        start_dump(5'd0, 5'd31);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_rf_addr", 32'(bus.rf_addr), 32'd0);
        chk("mid_rst_index", 32'(bus.out_index), 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);

        // A start while busy must not change the range in flight.
        bus.out_ready = 1'b0;
        start_dump(5'd10, 5'd12);
        start_dump(5'd20, 5'd25);
        chk("ignored_start_index", 32'(bus.out_index), 32'd10);
        chk("ignored_start_data", bus.out_data, rf_val(5'd10));
        collect(5'd10, 3, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
